pingpong_hit_judge: RTL

//  Pipelined, multi-paddle successor of the combinational ball/paddle collision and table-edge check.
//  Per accepted ball sample: signed squared-distance test against N_PAT paddles, gated by a per-paddle

---
 rtl/pingpong_hit_judge_if.sv | 43 ++++
 rtl/pingpong_hit_judge.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_hit_judge_if.sv
// ---------------------------------------------------------------------------
// pingpong_hit_judge_if
// Bundle between the motion/position update logic (master) and the hit
// judge (slave). The same bundle carries the judged result back to the
// score/bounce controller side.
//   in_valid    sample strobe for ball_loc / ball_vel / pat_loc
//   ball_loc    {y, x} unsigned pixels, CW bits per axis
//   ball_vel    {vy[15:0], vx[15:0]} two's complement
//   pat_loc     paddle i at [i*2*CW +: 2*CW], {y, x}
//   swing       per-paddle swing level
//   out_valid   result strobe, three clocks after in_valid
//   collide     per-paddle hit flags
//   hit_any     OR of collide
//   hit_idx     lowest-index hitting paddle
//   edg         table-edge code, held between samples
//   edge_event  one-clock pulse on edg 00 -> nonzero
// ---------------------------------------------------------------------------
interface pingpong_hit_judge_if #(
   parameter int CW    = 11,
   parameter int N_PAT = 2
);
   logic                  in_valid;
   logic [2*CW-1:0]       ball_loc;
   logic [31:0]           ball_vel;
   logic [N_PAT*2*CW-1:0] pat_loc;
   logic [N_PAT-1:0]      swing;
   logic                  out_valid;
   logic [N_PAT-1:0]      collide;
   logic                  hit_any;
   logic [1:0]            hit_idx;
   logic [1:0]            edg;
   logic                  edge_event;

   modport master (
      output in_valid, ball_loc, ball_vel, pat_loc, swing,
      input  out_valid, collide, hit_any, hit_idx, edg, edge_event
   );

   modport slave (
      input  in_valid, ball_loc, ball_vel, pat_loc, swing,
      output out_valid, collide, hit_any, hit_idx, edg, edge_event
   );
endinterface

// File: rtl/pingpong_hit_judge.sv
// ---------------------------------------------------------------------------
// pingpong_hit_judge
// Three-stage pipelined ball/paddle collision judge with table-edge check.
// Each accepted sample is tested against N_PAT paddles with a signed
// squared-distance compare, gated by a per-paddle swing window and a
// post-hit cooldown. One sample per clock, fixed latency, no backpressure.
// Ports:
//   clk    system clock
//   rst_n  synchronous reset, active low
//   bus    pingpong_hit_judge_if.slave (sample in, judged result out)
// ---------------------------------------------------------------------------
module pingpong_hit_judge #(
   parameter int CW        = 11,
   parameter int N_PAT     = 2,
   parameter int BALL_R    = 20,
   parameter int PAT_R     = 60,
   parameter int X_MAX     = 1280,
   parameter int Y_MAX     = 790,
   parameter int SWING_WIN = 16,
   parameter int COOLDOWN  = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   pingpong_hit_judge_if.slave bus
);

   localparam int                D2_W     = 2*CW + 3;
   localparam logic [D2_W-1:0]   R2       = D2_W'((BALL_R + PAT_R) * (BALL_R + PAT_R));
   localparam logic [CW-1:0]     X_MAX_C  = CW'(X_MAX);
   localparam logic [CW-1:0]     X_MID_C  = CW'(X_MAX / 2);
   localparam logic [CW-1:0]     Y_MAX_C  = CW'(Y_MAX);
   localparam logic [CW-1:0]     ONE_C    = CW'(1);
   localparam logic [7:0]        WIN_LOAD = 8'(SWING_WIN);
   localparam logic [7:0]        CD_LOAD  = 8'(COOLDOWN);

   // Square of a signed difference, widened so the sum of two squares
   // cannot overflow.
   function automatic logic [D2_W-1:0] sq(input logic signed [CW:0] v);
      logic signed [2*CW+1:0] ve;
      logic signed [2*CW+1:0] p;
      ve = {{(CW+1){v[CW]}}, v};
      p  = ve * ve;
      return {1'b0, $unsigned(p)};
   endfunction

   function automatic logic [1:0] lowest_idx(input logic [N_PAT-1:0] v);
      logic [1:0] r;
      r = 2'd0;
      for (int i = N_PAT - 1; i >= 0; i--) begin
         if (v[i]) r = 2'(i);
      end
      return r;
   endfunction

   // Top/bottom rows take precedence; there the side is decided by which
   // half of the table the ball is in.
   function automatic logic [1:0] edge_code(input logic [CW-1:0]        x,
                                            input logic [CW-1:0]        y,
                                            input logic signed [15:0]   vx);
      logic [1:0] r;
      if (y <= ONE_C || y > Y_MAX_C)   r = (x > X_MID_C) ? 2'b01 : 2'b10;
      else if (x > X_MAX_C)            r = 2'b01;
      else if (x <= ONE_C && vx < 0)   r = 2'b10;
      else                             r = 2'b00;
      return r;
   endfunction

   logic [CW-1:0]          ball_x;
   logic [CW-1:0]          ball_y;
   logic signed [15:0]     ball_vx;
   logic                   unused_vy;

   logic [N_PAT-1:0]       swing_prev;
   logic [N_PAT-1:0]       rise;
   logic [7:0]             win_cnt [N_PAT];
   logic [7:0]             cd_cnt  [N_PAT];
   logic [N_PAT-1:0]       win_open;

   logic                   vld_p0;
   logic signed [CW:0]     dx_p0 [N_PAT];
   logic signed [CW:0]     dy_p0 [N_PAT];
   logic [N_PAT-1:0]       win_open_p0;
   logic [1:0]             edg_p0;

   logic                   vld_p1;
   logic [D2_W-1:0]        d2_p1 [N_PAT];
   logic [N_PAT-1:0]       win_open_p1;
   logic [1:0]             edg_p1;

   logic [N_PAT-1:0]       cand;

   logic                   vld_p2;
   logic [N_PAT-1:0]       collide_p2;
   logic                   hit_any_p2;
   logic [1:0]             hit_idx_p2;
   logic [1:0]             edg_p2;
   logic                   edge_event_p2;

   assign ball_x    = bus.ball_loc[CW-1:0];
   assign ball_y    = bus.ball_loc[2*CW-1:CW];
   assign ball_vx   = bus.ball_vel[15:0];
   assign unused_vy = ^bus.ball_vel[31:16];

   // A held-high swing produces a single rising edge, so it cannot re-arm.
   assign rise = bus.swing & ~swing_prev;

   always_comb begin
      win_open = '0;
      for (int i = 0; i < N_PAT; i++) begin
         win_open[i] = (win_cnt[i] != 8'd0);
      end
   end

   // ---- Stage 1: signed per-axis differences, window and edge capture ----
   always_ff @(posedge clk) begin
      if (!rst_n) vld_p0 <= 1'b0;
      else        vld_p0 <= bus.in_valid;
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N_PAT; i++) begin
         dx_p0[i] <= $signed({1'b0, ball_x}) - $signed({1'b0, bus.pat_loc[i*2*CW +: CW]});
         dy_p0[i] <= $signed({1'b0, ball_y}) - $signed({1'b0, bus.pat_loc[i*2*CW + CW +: CW]});
      end
      win_open_p0 <= win_open;
      edg_p0      <= edge_code(ball_x, ball_y, ball_vx);
   end

   // ---- Stage 2: squared distance ----
   always_ff @(posedge clk) begin
      if (!rst_n) vld_p1 <= 1'b0;
      else        vld_p1 <= vld_p0;
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N_PAT; i++) begin
         d2_p1[i] <= sq(dx_p0[i]) + sq(dy_p0[i]);
      end
      win_open_p1 <= win_open_p0;
      edg_p1      <= edg_p0;
   end

   // ---- Stage 3: hit decision, cooldown and registered result ----
   // Strict less-than: touching exactly at R2 is not a hit.
   always_comb begin
      cand = '0;
      for (int i = 0; i < N_PAT; i++) begin
         cand[i] = vld_p1 & win_open_p1[i] & (d2_p1[i] < R2) & (cd_cnt[i] == 8'd0);
      end
   end

   // edg_p2 doubles as the previous-edge register: it only moves on valid
   // samples, so comparing against it gives the 00 -> nonzero transition.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p2        <= 1'b0;
         collide_p2    <= '0;
         hit_any_p2    <= 1'b0;
         hit_idx_p2    <= 2'd0;
         edg_p2        <= 2'b00;
         edge_event_p2 <= 1'b0;
      end else begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            collide_p2    <= cand;
            hit_any_p2    <= |cand;
            hit_idx_p2    <= lowest_idx(cand);
            edg_p2        <= edg_p1;
            edge_event_p2 <= (edg_p1 != 2'b00) && (edg_p2 == 2'b00);
         end else begin
            collide_p2    <= '0;
            hit_any_p2    <= 1'b0;
            hit_idx_p2    <= 2'd0;
            edge_event_p2 <= 1'b0;
         end
      end
   end

   // A hit closes the window ahead of any same-clock swing edge, so one
   // swing gives at most one hit. Cooldown counts valid samples, not clocks.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         swing_prev <= '0;
         for (int i = 0; i < N_PAT; i++) begin
            win_cnt[i] <= 8'd0;
            cd_cnt[i]  <= 8'd0;
         end
      end else begin
         swing_prev <= bus.swing;
         for (int i = 0; i < N_PAT; i++) begin
            if (cand[i])                 win_cnt[i] <= 8'd0;
            else if (rise[i])            win_cnt[i] <= WIN_LOAD;
            else if (win_cnt[i] != 8'd0) win_cnt[i] <= win_cnt[i] - 8'd1;

            if (cand[i])                           cd_cnt[i] <= CD_LOAD;
            else if (vld_p1 && cd_cnt[i] != 8'd0)  cd_cnt[i] <= cd_cnt[i] - 8'd1;
         end
      end
   end

   assign bus.out_valid  = vld_p2;
   assign bus.collide    = collide_p2;
   assign bus.hit_any    = hit_any_p2;
   assign bus.hit_idx    = hit_idx_p2;
   assign bus.edg        = edg_p2;
   assign bus.edge_event = edge_event_p2;

endmodule
